// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer driving a majority-vote bit filter.
// Optional feature: UART_RX_FALSE_START_EN rejects start bits the filter decides were high.
module uart_rx_deframer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxclk,
    input  logic       i_rxd,
    input  logic [1:0] i_wls,
    input  logic       i_pen,
    input  logic       i_eps,
    input  logic       i_sp,
    input  logic       i_filt_q,
    output logic       o_filt_sample,
    output logic       o_filt_clear,
    output logic [7:0] o_rxdata,
    output logic       o_rxvalid,
    output logic       o_pe,
    output logic       o_fe,
    output logic       o_bi
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_bitidx;
    logic [7:0]      r_data;
    logic            r_par;
    logic            r_pe_pend;
    logic            r_rxd_last;
    logic [1:0]      r_wls;
    logic            r_pen;
    logic            r_eps;
    logic            r_sp;

    logic            w_active;
    logic            w_decide;
    logic            w_last_bit;
    logic            w_break;

    assign w_active      = (r_state != S_IDLE);
    assign w_decide      = w_active && i_rxclk && (r_tick == LAST_TICK);
    assign o_filt_sample = w_active && i_rxclk && (r_tick != LAST_TICK);
    assign o_filt_clear  = !w_active || w_decide;
    assign w_last_bit    = (r_bitidx == (3'(r_wls) + 3'd4));
    // Parity bit is cleared at frame start, so it reads 0 when parity is disabled.
    assign w_break       = (r_data == 8'h00) && !r_par && !i_filt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bitidx   <= 3'd0;
            r_data     <= 8'h00;
            r_par      <= 1'b0;
            r_pe_pend  <= 1'b0;
            r_rxd_last <= 1'b0;
            r_wls      <= 2'b00;
            r_pen      <= 1'b0;
            r_eps      <= 1'b0;
            r_sp       <= 1'b0;
            o_rxdata   <= 8'h00;
            o_rxvalid  <= 1'b0;
            o_pe       <= 1'b0;
            o_fe       <= 1'b0;
            o_bi       <= 1'b0;
        end else begin
            // Tracked every cycle so a line left low after a frame needs a fresh fall.
            r_rxd_last <= i_rxd;
            o_rxvalid  <= 1'b0;
            if (w_active && i_rxclk) begin
                r_tick <= r_tick + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    if (r_rxd_last && !i_rxd) begin
                        r_state   <= S_START;
                        r_wls     <= i_wls;
                        r_pen     <= i_pen;
                        r_eps     <= i_eps;
                        r_sp      <= i_sp;
                        r_data    <= 8'h00;
                        r_par     <= 1'b0;
                        r_pe_pend <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_decide) begin
`ifdef UART_RX_FALSE_START_EN
                        if (i_filt_q) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state  <= S_DATA;
                            r_bitidx <= 3'd0;
                        end
`else
                        r_state  <= S_DATA;
                        r_bitidx <= 3'd0;
`endif
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_data[r_bitidx] <= i_filt_q;
                        r_bitidx         <= r_bitidx + 3'd1;
                        if (w_last_bit) begin
                            r_state <= r_pen ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_par <= i_filt_q;
                        if (r_sp) begin
                            r_pe_pend <= (i_filt_q == r_eps);
                        end else if (r_eps) begin
                            r_pe_pend <= (^r_data) ^ i_filt_q;
                        end else begin
                            r_pe_pend <= !((^r_data) ^ i_filt_q);
                        end
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        o_rxdata  <= w_break ? 8'h00 : r_data;
                        o_pe      <= r_pen && r_pe_pend;
                        o_fe      <= !i_filt_q;
                        o_bi      <= w_break;
                        o_rxvalid <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed bench for uart_rx_deframer with a majority filter model.
module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxclk;
    logic       rxd;
    logic [1:0] wls;
    logic       pen, eps, sp;
    logic       filt_q;
    logic       filt_sample, filt_clear;
    logic [7:0] rxdata;
    logic       rxvalid, pe, fe, bi;

    int total = 0;
    int bad   = 0;
    int vcount = 0;
    logic [7:0] cap_data;
    logic cap_pe, cap_fe, cap_bi;
    int f_ones = 0;
    int f_n    = 0;

    uart_rx_deframer #(.OVERSAMPLE(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_rxclk(rxclk), .i_rxd(rxd),
        .i_wls(wls), .i_pen(pen), .i_eps(eps), .i_sp(sp), .i_filt_q(filt_q),
        .o_filt_sample(filt_sample), .o_filt_clear(filt_clear),
        .o_rxdata(rxdata), .o_rxvalid(rxvalid), .o_pe(pe), .o_fe(fe), .o_bi(bi)
    );

    always #5 clk = ~clk;

    initial begin
        rxclk = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 rxclk = 1'b1;
            @(posedge clk);
            #1 rxclk = 1'b0;
        end
    end

    // Majority-vote filter model.
    always @(posedge clk) begin
        if (filt_clear) begin
            f_ones <= 0;
            f_n    <= 0;
        end else if (filt_sample) begin
            f_ones <= f_ones + (rxd ? 1 : 0);
            f_n    <= f_n + 1;
        end
    end
    assign filt_q = (2 * f_ones > f_n);

    always @(negedge clk) begin
        if (rxvalid) begin
            vcount   = vcount + 1;
            cap_data = rxdata;
            cap_pe   = pe;
            cap_fe   = fe;
            cap_bi   = bi;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        while (rxclk !== 1'b1) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input int wl, input logic use_par,
                              input logic par, input logic stop);
        rxd = 1'b1;
        repeat (3) tick();
        rxd = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < wl; i++) begin
            rxd = d[i];
            repeat (16) tick();
        end
        if (use_par) begin
            rxd = par;
            repeat (16) tick();
        end
        rxd = stop;
        repeat (16) tick();
        repeat (2) tick();
        rxd = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (rxvalid !== 1'b0) begin bad++; $display("FAIL reset_rxvalid got %b exp 0", rxvalid); end
        total++; if (rxdata !== 8'h00) begin bad++; $display("FAIL reset_rxdata got %h exp 00", rxdata); end
        total++; if ({pe, fe, bi} !== 3'b000) begin bad++; $display("FAIL reset_status got %b exp 000", {pe, fe, bi}); end
        total++; if (filt_clear !== 1'b1) begin bad++; $display("FAIL reset_filt_clear got %b exp 1", filt_clear); end
        total++; if (filt_sample !== 1'b0) begin bad++; $display("FAIL reset_filt_sample got %b exp 0", filt_sample); end
    endtask

    task automatic test_8n1_timing();
        logic [9:0] bits;
        int c0;
        bits = {1'b1, 8'hA5, 1'b0};
        wls = 2'b11; pen = 1'b0;
        rxd = 1'b1;
        repeat (3) tick();
        c0 = vcount;
        for (int i = 0; i < 159; i++) begin
            rxd = bits[i / 16];
            tick();
        end
        total++; if (vcount != c0 || rxvalid !== 1'b0) begin bad++; $display("FAIL 8n1_early got count %0d exp %0d", vcount - c0, 0); end
        tick();
        total++; if (rxvalid !== 1'b1) begin bad++; $display("FAIL 8n1_latency got rxvalid %b exp 1", rxvalid); end
        repeat (3) tick();
        total++; if (vcount - c0 != 1) begin bad++; $display("FAIL 8n1_pulses got %0d exp 1", vcount - c0); end
        total++; if (cap_data !== 8'hA5) begin bad++; $display("FAIL 8n1_data got %h exp a5", cap_data); end
        total++; if ({cap_pe, cap_fe, cap_bi} !== 3'b000) begin bad++; $display("FAIL 8n1_status got %b exp 000", {cap_pe, cap_fe, cap_bi}); end
    endtask

    task automatic test_7e1_parity();
        int c0;
        wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        c0 = vcount;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        total++; if (vcount - c0 != 1) begin bad++; $display("FAIL 7e1_pulses got %0d exp 1", vcount - c0); end
        total++; if (cap_data !== 8'h41) begin bad++; $display("FAIL 7e1_data got %h exp 41", cap_data); end
        total++; if ({cap_pe, cap_fe} !== 2'b10) begin bad++; $display("FAIL 7e1_pe_fe got %b exp 10", {cap_pe, cap_fe}); end
        wls = 2'b11; pen = 1'b0; eps = 1'b0;
    endtask

    task automatic test_false_start();
        int c0;
        wls = 2'b11; pen = 1'b0;
        rxd = 1'b1;
        repeat (3) tick();
        c0 = vcount;
        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        repeat (170) tick();
`ifdef UART_RX_FALSE_START_EN
        total++; if (vcount - c0 != 0) begin bad++; $display("FAIL glitch_rejected got %0d pulses exp 0", vcount - c0); end
`else
        total++; if (vcount - c0 != 1) begin bad++; $display("FAIL glitch_frame got %0d pulses exp 1", vcount - c0); end
        total++; if (cap_data !== 8'hFF || cap_fe !== 1'b0) begin bad++; $display("FAIL glitch_data got %h fe %b exp ff fe 0", cap_data, cap_fe); end
`endif
        c0 = vcount;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        total++; if (vcount - c0 != 1 || cap_data !== 8'h3C) begin bad++; $display("FAIL after_glitch got %0d/%h exp 1/3c", vcount - c0, cap_data); end
    endtask

    task automatic test_framing_error();
        int c0;
        c0 = vcount;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
        total++; if (vcount - c0 != 1) begin bad++; $display("FAIL fe_pulses got %0d exp 1", vcount - c0); end
        total++; if (cap_data !== 8'h55) begin bad++; $display("FAIL fe_data got %h exp 55", cap_data); end
        total++; if ({cap_fe, cap_bi} !== 2'b10) begin bad++; $display("FAIL fe_flags got %b exp 10", {cap_fe, cap_bi}); end
        repeat (20) tick();
    endtask

    task automatic test_break();
        int c0;
        rxd = 1'b1;
        repeat (3) tick();
        c0 = vcount;
        rxd = 1'b0;
        repeat (320) tick();
        total++; if (vcount - c0 != 1) begin bad++; $display("FAIL break_pulses got %0d exp 1", vcount - c0); end
        total++; if (cap_data !== 8'h00) begin bad++; $display("FAIL break_data got %h exp 00", cap_data); end
        total++; if ({cap_bi, cap_fe} !== 2'b11) begin bad++; $display("FAIL break_flags got %b exp 11", {cap_bi, cap_fe}); end
        rxd = 1'b1;
        repeat (20) tick();
        c0 = vcount;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        total++; if (vcount - c0 != 1 || cap_data !== 8'hC3 || cap_bi !== 1'b0) begin bad++; $display("FAIL after_break got %0d/%h/%b exp 1/c3/0", vcount - c0, cap_data, cap_bi); end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        rxd = 1'b1;
        repeat (3) tick();
        c0 = vcount;
        rxd = 1'b0;
        repeat (16) tick();
        rxd = 1'b1;
        repeat (24) tick();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (filt_clear !== 1'b1) begin bad++; $display("FAIL midreset_clear got %b exp 1", filt_clear); end
        repeat (200) tick();
        total++; if (vcount - c0 != 0) begin bad++; $display("FAIL midreset_novalid got %0d exp 0", vcount - c0); end
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        total++; if (vcount - c0 != 1 || cap_data !== 8'h81) begin bad++; $display("FAIL midreset_next got %0d/%h exp 1/81", vcount - c0, cap_data); end
        total++; if ({cap_pe, cap_fe, cap_bi} !== 3'b000) begin bad++; $display("FAIL midreset_status got %b exp 000", {cap_pe, cap_fe, cap_bi}); end
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        test_reset();
        test_8n1_timing();
        test_7e1_parity();
        test_false_start();
        test_framing_error();
        test_break();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

UART receive deframer that sits directly downstream of the majority-vote bit filter in the receive path. It detects the start bit on the synchronized RXD line and steps through start, data, parity and stop bits on the 16x baud tick. Each bit period it drives the filter's SAMPLE/CLEAR controls, takes the filter's Q output as the bit decision, and assembles a character with parity, framing and break status.

## Interface
- Parameters:
- OVERSAMPLE, 16: RXCLK ticks per bit period; power of two, ≥ 4.
- Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; **synchronous, active-high**, one clock domain (CLK).
- RXCLK  in  1  oversample tick enable; high for one CLK cycle; at most once every 2 CLK cycles.
- RXD  in  1  synchronized serial input; also wired to the filter's D input.
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- PEN  in  1  parity enable.
- EPS  in  1  even parity select.
- SP  in  1  stick parity.
- FILT_Q  in  1  filter output; 1 means the bit was majority-high.
- FILT_SAMPLE  out  1  filter sample strobe.
- FILT_CLEAR  out  1  filter clear.
- RXDATA  out  8  received character, LSB-aligned; unused upper bits are 0.
- RXVALID  out  1  one-cycle pulse when RXDATA and the status bits are updated.
- PE, FE, BI  out  1 each  parity error, framing error, break; valid while RXVALID=1 and held until the next RXVALID.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter: log2(OVERSAMPLE) bits; advances on RXCLK and wraps from OVERSAMPLE-1 to 0.
- Decision tick: tick OVERSAMPLE-1.
- Filter control outside IDLE: FILT_SAMPLE = RXCLK when not on the decision tick, else 0. FILT_CLEAR = 1 on the decision tick (RXCLK=1), else 0. Each bit decision is therefore based on OVERSAMPLE-1 samples.
- Filter control in IDLE: FILT_CLEAR=1 and FILT_SAMPLE=0.
- IDLE: keeps the last RXD value. A transition from 1 to 0 does the following:
  - moves to START;
  - zeroes the tick counter;
  - latches WLS, PEN, EPS and SP for the whole frame. Changes to these inputs mid-frame are ignored.
- START, on the decision tick:
  - FILT_Q=0 → go to DATA, bit index 0.
  - FILT_Q=1 → false start; return to IDLE with no RXVALID. Applies with UART_RX_FALSE_START_EN only.
- DATA: on each decision tick, shift FILT_Q in LSB-first. After the latched word length, go to PARITY if PEN=1, otherwise to STOP.
- PARITY, on the decision tick, capture the parity bit. PE=1 when:
  - SP=0, EPS=0 (odd): the count of ones in data plus parity is even;
  - SP=0, EPS=1 (even): the count of ones in data plus parity is odd;
  - SP=1: the parity bit ≠ !EPS.
- STOP: only the first stop bit is checked. On the decision tick:
  - FE = !FILT_Q;
  - BI = 1 if every data bit, the parity bit (if enabled) and the stop bit are all 0; in that case RXDATA=0;
  - register the results and go to IDLE.
- After a frame ending with RXD low (break or FE), the next frame needs a new 1→0 transition, so the line must return high first.

## Timing
- Reset values: state IDLE, tick counter 0, RXDATA=0, RXVALID=0, PE=FE=BI=0, FILT_SAMPLE=0, FILT_CLEAR=1.
- FILT_SAMPLE and FILT_CLEAR are combinational from state, tick counter and RXCLK. All other outputs are registered.
- FILT_Q is sampled in the decision-tick cycle. The last sample comes at least 2 CLK cycles earlier, which gives the filter time to settle.
- RXVALID rises in the CLK cycle after the stop-bit decision tick, together with RXDATA, PE, FE and BI.
- Frame length: start edge to RXVALID is (1 + WL + PEN + 1)·OVERSAMPLE ticks plus 1 CLK.
- Reset mid-frame: the next cycle is in IDLE, no RXVALID is produced, and the partial character is discarded.
- An RXD 1→0 transition in the cycle where STOP returns to IDLE is not detected. The next start needs a fresh transition.

## Configuration
- UART_RX_FALSE_START_EN:
  - Defined: START checks FILT_Q on its decision tick and returns to IDLE if it is 1, so glitches shorter than half a bit are rejected.
  - Undefined: any 1→0 transition commits to a full frame, and FILT_Q is ignored in START.

## Test plan
- 8N1 frame, 0xA5 (WLS=11, PEN=0), RXCLK every 4 CLK → one RXVALID pulse, RXDATA=0xA5, PE=FE=BI=0, exactly 160 ticks after the start edge (+1 CLK).
- 7E1 frame, data 0x41, parity bit forced to 1 (WLS=10, PEN=1, EPS=1) → RXDATA=0x41, PE=1, FE=0.
- RXD low for 3 ticks, then high, with the macro defined → no RXVALID; a following valid 0x3C frame is received correctly. Macro undefined → one RXVALID with FE=0 and RXDATA=0xFF for 8N1 on a high line.
- 8N1 frame 0x55 with the stop bit held low → RXDATA=0x55, FE=1, BI=0.
- Line held low for 2 frame times, 8N1 → RXDATA=0x00, BI=1, FE=1, a single RXVALID. No second frame until RXD goes high and then falls again.
- RST asserted for 1 cycle mid-DATA → RXVALID stays 0, FILT_CLEAR=1 the next cycle, and the next frame 0x81 is received correctly.
